// File: rtl/pam4_slicer_ber.sv
// PAM4 slicer and BER accumulator. Slices noisy signed samples into PAM4
// symbols, compares them against buffered reference symbols and counts
// symbol and Gray-coded bit errors over a measurement window.
module pam4_slicer_ber #(
    parameter int                 FIFO_DEPTH = 16,
    parameter int                 CNT_W      = 32,
    parameter logic signed [7:0]  THR_LO     = -8'sd64,
    parameter logic signed [7:0]  THR_MID    = 8'sd0,
    parameter logic signed [7:0]  THR_HI     = 8'sd64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    target_syms,
    input  logic [1:0]          ref_sym,
    input  logic                ref_valid,
    output logic                ref_ready,
    input  logic signed [7:0]   rx_sample,
    input  logic                rx_valid,
    output logic [1:0]          rx_sym,
    output logic                rx_sym_valid,
    output logic [CNT_W-1:0]    sym_count,
    output logic [CNT_W-1:0]    sym_err_count,
    output logic [CNT_W-1:0]    bit_err_count,
    output logic                underrun,
    output logic                busy,
    output logic                done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   target_reg;
    logic [CNT_W-1:0]   sym_count_reg, sym_err_count_reg, bit_err_count_reg;
    logic               underrun_reg;
    logic [1:0]         rx_sym_reg;
    logic               rx_sym_valid_reg;

    logic [1:0]         mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_reg, rd_ptr_reg;

    // Threshold slicer; all comparisons are signed.
    function automatic logic [1:0] slice(input logic signed [7:0] s);
        logic [1:0] r;
        if (s < THR_LO)       r = 2'd0;
        else if (s < THR_MID) r = 2'd1;
        else if (s < THR_HI)  r = 2'd2;
        else                  r = 2'd3;
        return r;
    endfunction

    // Gray code so adjacent levels differ by one bit: 0->00 1->01 2->11 3->10.
    function automatic logic [1:0] gray(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    // Saturating add of a small increment; counters stick at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic               run;
    logic               fifo_empty, fifo_full;
    logic               start_acc, flush, push, cmp_event, underrun_event;
    logic [1:0]         head_sym, cmp_sym, gray_diff, bit_errs;
    logic [CNT_W-1:0]   sym_count_inc;
    logic               target_hit;

    assign run        = (state_reg == RUN);
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Start is only honoured outside RUN; abort always wins.
    assign start_acc      = start && !abort && !run;
    assign flush          = start_acc || abort;
    assign push           = ref_valid && ref_ready && !abort;
    assign cmp_event      = run && rx_valid && !fifo_empty && !abort;
    assign underrun_event = run && rx_valid && fifo_empty && !abort;

    assign head_sym      = mem[rd_ptr_reg[AW-1:0]];
    assign cmp_sym       = slice(rx_sample);
    assign gray_diff     = gray(cmp_sym) ^ gray(head_sym);
    assign bit_errs      = {1'b0, gray_diff[0]} + {1'b0, gray_diff[1]};
    assign sym_count_inc = sat_add(sym_count_reg, 2'd1);
    assign target_hit    = cmp_event && (target_reg != '0) &&
                           (sym_count_inc == target_reg);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: abort beats start; the final compare moves to DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && !abort) state_next = RUN;
            RUN: begin
                if (abort)           state_next = IDLE;
                else if (target_hit) state_next = DONE;
            end
            DONE: begin
                if (abort)      state_next = IDLE;
                else if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reference FIFO pointers; a flush discards everything including this cycle's push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)      wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (cmp_event) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Reference FIFO storage.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= ref_sym;
    end

    // Measurement counters, underrun flag and latched target.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            target_reg        <= '0;
            sym_count_reg     <= '0;
            sym_err_count_reg <= '0;
            bit_err_count_reg <= '0;
            underrun_reg      <= 1'b0;
        end else if (start_acc) begin
            target_reg        <= target_syms;
            sym_count_reg     <= '0;
            sym_err_count_reg <= '0;
            bit_err_count_reg <= '0;
            underrun_reg      <= 1'b0;
        end else begin
            if (cmp_event) begin
                sym_count_reg     <= sym_count_inc;
                sym_err_count_reg <= sat_add(sym_err_count_reg,
                                             {1'b0, cmp_sym != head_sym});
                bit_err_count_reg <= sat_add(bit_err_count_reg, bit_errs);
            end
            if (underrun_event) underrun_reg <= 1'b1;
        end
    end

    // Registered slicer output, active in every state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sym_reg       <= 2'd0;
            rx_sym_valid_reg <= 1'b0;
        end else begin
            rx_sym_valid_reg <= rx_valid;
            if (rx_valid) rx_sym_reg <= cmp_sym;
        end
    end

    assign ref_ready     = run && !fifo_full;
    assign rx_sym        = rx_sym_reg;
    assign rx_sym_valid  = rx_sym_valid_reg;
    assign sym_count     = sym_count_reg;
    assign sym_err_count = sym_err_count_reg;
    assign bit_err_count = bit_err_count_reg;
    assign underrun      = underrun_reg;
    assign busy          = run;
    assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_pam4_slicer_ber.sv
// Directed testbench for pam4_slicer_ber: slicer sweep, error-free and
// erroring runs, underrun, FIFO full, abort/restart and async reset.
module tb_pam4_slicer_ber;

    localparam int CNT_W = 32;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start, abort;
    logic [CNT_W-1:0]   target_syms;
    logic [1:0]         ref_sym;
    logic               ref_valid, ref_ready;
    logic signed [7:0]  rx_sample;
    logic               rx_valid;
    logic [1:0]         rx_sym;
    logic               rx_sym_valid;
    logic [CNT_W-1:0]   sym_count, sym_err_count, bit_err_count;
    logic               underrun, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pam4_slicer_ber #(.FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .target_syms(target_syms), .ref_sym(ref_sym), .ref_valid(ref_valid),
        .ref_ready(ref_ready), .rx_sample(rx_sample), .rx_valid(rx_valid),
        .rx_sym(rx_sym), .rx_sym_valid(rx_sym_valid), .sym_count(sym_count),
        .sym_err_count(sym_err_count), .bit_err_count(bit_err_count),
        .underrun(underrun), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample value sitting in the middle of each PAM4 decision region.
    function automatic logic [7:0] samp(input logic [1:0] s);
        logic [7:0] v;
        case (s)
            2'd0: v = 8'h9C;   // -100
            2'd1: v = 8'hE2;   // -30
            2'd2: v = 8'h1E;   // 30
            default: v = 8'h64; // 100
        endcase
        return v;
    endfunction

    // Abort any measurement, then start a new one with the given target.
    task automatic begin_meas(input logic [CNT_W-1:0] t);
        ref_valid = 1'b0; rx_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; target_syms = t; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; target_syms = '0;
        ref_sym = 2'd0; ref_valid = 1'b0; rx_sample = 8'sd0; rx_valid = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL reset_state busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (ref_ready !== 1'b0 || rx_sym_valid !== 1'b0 || underrun !== 1'b0) begin errors++;
            $display("FAIL reset_flags ref_ready=%b rx_sym_valid=%b underrun=%b expected 0", ref_ready, rx_sym_valid, underrun); end
        checks++; if (sym_count !== 0 || sym_err_count !== 0 || bit_err_count !== 0 || rx_sym !== 2'd0) begin errors++;
            $display("FAIL reset_counts sym=%0d serr=%0d berr=%0d rx_sym=%0d expected 0", sym_count, sym_err_count, bit_err_count, rx_sym); end
        rstn = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_slicer();
        logic [7:0] sl_in  [8] = '{8'h80, 8'hBF, 8'hC0, 8'hFF, 8'h00, 8'h3F, 8'h40, 8'h7F};
        logic [1:0] sl_exp [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1; rx_sample = sl_in[i];
            tick();
            $display("slicer: sample %0d -> sym %0d", rx_sample, rx_sym);
            checks++; if (rx_sym !== sl_exp[i] || rx_sym_valid !== 1'b1) begin errors++;
                $display("FAIL slicer[%0d] rx_sym=%0d valid=%b expected %0d 1", i, rx_sym, rx_sym_valid, sl_exp[i]); end
        end
        rx_valid = 1'b0; rx_sample = 8'h80;
        tick();
        checks++; if (rx_sym !== 2'd3 || rx_sym_valid !== 1'b0) begin errors++;
            $display("FAIL slicer_hold rx_sym=%0d valid=%b expected 3 0", rx_sym, rx_sym_valid); end
        checks++; if (sym_count !== 0 || underrun !== 1'b0) begin errors++;
            $display("FAIL slicer_idle_count sym=%0d underrun=%b expected 0 0", sym_count, underrun); end
    endtask

    task automatic test_error_free();
        begin_meas(32'd100);
        checks++; if (busy !== 1'b1 || sym_count !== 0) begin errors++;
            $display("FAIL ef_start busy=%b sym=%0d expected 1 0", busy, sym_count); end
        for (int i = 0; i <= 100; i++) begin
            ref_valid = (i < 100); ref_sym = 2'(i % 4);
            rx_valid  = (i > 0);   rx_sample = samp(2'((i + 3) % 4));
            tick();
            if (i == 50) begin
                checks++; if (sym_count !== 32'd50) begin errors++;
                    $display("FAIL ef_mid sym=%0d expected 50", sym_count); end
            end
            if (i == 99) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1 || sym_count !== 32'd99) begin errors++;
                    $display("FAIL ef_99 done=%b busy=%b sym=%0d expected 0 1 99", done, busy, sym_count); end
            end
        end
        ref_valid = 1'b0; rx_valid = 1'b0;
        $display("error_free: sym=%0d serr=%0d berr=%0d done=%b", sym_count, sym_err_count, bit_err_count, done);
        checks++; if (sym_count !== 32'd100 || done !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL ef_done sym=%0d done=%b busy=%b expected 100 1 0", sym_count, done, busy); end
        checks++; if (sym_err_count !== 0 || bit_err_count !== 0 || underrun !== 1'b0) begin errors++;
            $display("FAIL ef_errs serr=%0d berr=%0d underrun=%b expected 0 0 0", sym_err_count, bit_err_count, underrun); end
        tick();
        checks++; if (done !== 1'b1 || ref_ready !== 1'b0) begin errors++;
            $display("FAIL ef_done_hold done=%b ref_ready=%b expected 1 0", done, ref_ready); end
    endtask

    task automatic test_errors();
        logic [1:0] refs [4] = '{2'd0, 2'd0, 2'd3, 2'd1};
        logic [7:0] smps [4] = '{8'h9C, 8'h64, 8'h9C, 8'h1E};
        begin_meas(32'd4);
        for (int i = 0; i <= 4; i++) begin
            ref_valid = (i < 4); ref_sym = refs[i % 4];
            rx_valid  = (i > 0); rx_sample = smps[(i + 3) % 4];
            tick();
        end
        ref_valid = 1'b0; rx_valid = 1'b0;
        $display("errors: sym=%0d serr=%0d berr=%0d", sym_count, sym_err_count, bit_err_count);
        checks++; if (sym_count !== 32'd4 || sym_err_count !== 32'd3 || bit_err_count !== 32'd3) begin errors++;
            $display("FAIL err_counts sym=%0d serr=%0d berr=%0d expected 4 3 3", sym_count, sym_err_count, bit_err_count); end
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL err_done done=%b expected 1", done); end
        // ref 0 (gray 00) vs sliced 2 (gray 11): two bit errors from one symbol.
        begin_meas(32'd1);
        ref_valid = 1'b1; ref_sym = 2'd0; tick();
        ref_valid = 1'b0; rx_valid = 1'b1; rx_sample = 8'h1E; tick();
        rx_valid = 1'b0;
        checks++; if (sym_err_count !== 32'd1 || bit_err_count !== 32'd2 || done !== 1'b1) begin errors++;
            $display("FAIL err_two_bits serr=%0d berr=%0d done=%b expected 1 2 1", sym_err_count, bit_err_count, done); end
        // abort beats start in the same cycle; counts held.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bit_err_count !== 32'd2) begin errors++;
            $display("FAIL abort_prio busy=%b done=%b berr=%0d expected 0 0 2", busy, done, bit_err_count); end
    endtask

    task automatic test_underrun();
        begin_meas(32'd0);
        ref_valid = 1'b1; ref_sym = 2'd2; rx_valid = 1'b1; rx_sample = 8'h1E;
        tick();
        ref_valid = 1'b0;
        checks++; if (underrun !== 1'b1 || sym_count !== 0) begin errors++;
            $display("FAIL underrun_set underrun=%b sym=%0d expected 1 0", underrun, sym_count); end
        tick();
        rx_valid = 1'b0;
        $display("underrun: underrun=%b sym=%0d", underrun, sym_count);
        checks++; if (sym_count !== 32'd1 || sym_err_count !== 0 || busy !== 1'b1) begin errors++;
            $display("FAIL underrun_pop sym=%0d serr=%0d busy=%b expected 1 0 1", sym_count, sym_err_count, busy); end
    endtask

    task automatic test_fifo_full();
        begin_meas(32'd0);
        for (int i = 0; i < 16; i++) begin
            ref_valid = 1'b1; ref_sym = 2'((i * 3) % 4);
            tick();
            checks++; if (ref_ready !== (i != 15)) begin errors++;
                $display("FAIL fifo_fill[%0d] ref_ready=%b expected %b", i, ref_ready, (i != 15)); end
        end
        // Blocked push plus a pop; space frees up for the following cycle.
        ref_sym = 2'd1; rx_valid = 1'b1; rx_sample = samp(2'd0);
        tick();
        ref_valid = 1'b0;
        checks++; if (ref_ready !== 1'b1 || sym_count !== 32'd1) begin errors++;
            $display("FAIL fifo_pop_full ref_ready=%b sym=%0d expected 1 1", ref_ready, sym_count); end
        for (int k = 1; k < 16; k++) begin
            rx_sample = samp(2'((k * 3) % 4));
            tick();
        end
        $display("fifo_full: sym=%0d serr=%0d", sym_count, sym_err_count);
        checks++; if (sym_count !== 32'd16 || sym_err_count !== 0 || underrun !== 1'b0) begin errors++;
            $display("FAIL fifo_order sym=%0d serr=%0d underrun=%b expected 16 0 0", sym_count, sym_err_count, underrun); end
        tick();
        rx_valid = 1'b0;
        checks++; if (underrun !== 1'b1 || sym_count !== 32'd16) begin errors++;
            $display("FAIL fifo_drained underrun=%b sym=%0d expected 1 16", underrun, sym_count); end
    endtask

    task automatic test_abort();
        begin_meas(32'd0);
        for (int i = 0; i < 8; i++) begin
            ref_valid = 1'b1; ref_sym = 2'(i % 4);
            rx_valid  = (i > 0); rx_sample = samp(2'((i + 3) % 4));
            tick();
        end
        ref_valid = 1'b0; rx_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (sym_count !== 32'd7 || busy !== 1'b1) begin errors++;
            $display("FAIL start_in_run sym=%0d busy=%b expected 7 1", sym_count, busy); end
        abort = 1'b1; tick(); abort = 1'b0;
        $display("abort: sym=%0d busy=%b", sym_count, busy);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || ref_ready !== 1'b0 || sym_count !== 32'd7) begin errors++;
            $display("FAIL abort_hold busy=%b done=%b ref_ready=%b sym=%0d expected 0 0 0 7", busy, done, ref_ready, sym_count); end
        start = 1'b1; target_syms = '0; tick(); start = 1'b0;
        checks++; if (sym_count !== 0 || busy !== 1'b1) begin errors++;
            $display("FAIL restart sym=%0d busy=%b expected 0 1", sym_count, busy); end
        rx_valid = 1'b1; rx_sample = samp(2'd3); tick(); rx_valid = 1'b0;
        checks++; if (underrun !== 1'b1 || sym_count !== 0) begin errors++;
            $display("FAIL abort_flush underrun=%b sym=%0d expected 1 0", underrun, sym_count); end
    endtask

    task automatic test_reset_mid();
        begin_meas(32'd0);
        for (int i = 0; i < 4; i++) begin
            ref_valid = 1'b1; ref_sym = 2'(i % 4);
            rx_valid  = (i > 0); rx_sample = samp(2'((i + 3) % 4));
            tick();
        end
        checks++; if (sym_count !== 32'd3 || rx_sym_valid !== 1'b1) begin errors++;
            $display("FAIL pre_reset sym=%0d rx_sym_valid=%b expected 3 1", sym_count, rx_sym_valid); end
        #2 rstn = 1'b0;
        #1;
        $display("reset_mid: sym=%0d busy=%b", sym_count, busy);
        checks++; if (sym_count !== 0 || busy !== 1'b0 || ref_ready !== 1'b0 || rx_sym_valid !== 1'b0 || rx_sym !== 2'd0) begin errors++;
            $display("FAIL async_reset sym=%0d busy=%b ref_ready=%b rx_sym_valid=%b rx_sym=%0d expected 0", sym_count, busy, ref_ready, rx_sym_valid, rx_sym); end
        ref_valid = 1'b0; rx_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_slicer();
        test_error_free();
        test_errors();
        test_underrun();
        test_fifo_full();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
